// File: rtl/conv_splitter_pkg.sv
// Shared definitions for the conv input splitter.
// Provides the skid-buffer state enum, default field widths and helpers that
// derive the packed-beat width and field offsets from the block parameters.
package conv_splitter_pkg;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Default geometry
    localparam int unsigned DEF_PIXEL_CHANNELS = 2;
    localparam int unsigned DEF_UNITS          = 8;
    localparam int unsigned DEF_WORD_WIDTH     = 8;
    localparam int unsigned DEF_CORES          = 4;
    localparam int unsigned DEF_KERNEL_W_MAX   = 3;
    localparam int unsigned DEF_TUSER_WIDTH    = 16;
    localparam int unsigned DEF_ZEROS_WIDTH    = 5;
    localparam int unsigned DEF_COUNT_WIDTH    = 32;

    // Width of all pixel channels together
    function automatic int unsigned pix_width(input int unsigned channels,
                                              input int unsigned units,
                                              input int unsigned word_w);
        return channels * units * word_w;
    endfunction

    // Width of the weight word vector
    function automatic int unsigned wgt_width(input int unsigned cores,
                                              input int unsigned kernel_w,
                                              input int unsigned word_w);
        return cores * kernel_w * word_w;
    endfunction

    // Offsets of the fields within the packed beat, LSB first
    function automatic int unsigned wgt_offset(input int unsigned pix_w);
        return pix_w;
    endfunction

    function automatic int unsigned tuser_offset(input int unsigned pix_w,
                                                 input int unsigned wgt_w);
        return pix_w + wgt_w;
    endfunction

    function automatic int unsigned pad_offset(input int unsigned pix_w,
                                               input int unsigned wgt_w,
                                               input int unsigned tuser_w);
        return pix_w + wgt_w + tuser_w;
    endfunction

    localparam int unsigned DEF_PIX_W = DEF_PIXEL_CHANNELS * DEF_UNITS * DEF_WORD_WIDTH;
    localparam int unsigned DEF_WGT_W = DEF_CORES * DEF_KERNEL_W_MAX * DEF_WORD_WIDTH;
    localparam int unsigned DEF_S_WIDTH = DEF_PIX_W + DEF_WGT_W + DEF_TUSER_WIDTH
                                        + DEF_ZEROS_WIDTH;

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry AXI-Stream skid buffer.
// Both s_ready and m_valid/m_data are registered, so s_ready never depends
// combinationally on m_ready. Strict FIFO order; synchronous active-high rst.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     upstream handshake, s_data payload in
//   m_valid/m_ready     downstream handshake, m_data payload out
module axis_skid_buffer
    import conv_splitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    skid_state_e           state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_c;
    logic                  out_c;

    assign in_c  = s_valid & s_ready_q;
    assign out_c = m_valid_q & m_ready;

    // Next state and datapath loads
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_c) begin
                    out_d   = s_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_c && out_c) begin
                    out_d = s_data;
                end else if (in_c) begin
                    skid_d  = s_data;
                    state_d = FULL;
                end else if (out_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so only the drain can happen
                if (out_c) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags follow the next state so they stay registered
        s_ready_d = (state_d != FULL);
        m_valid_d = (state_d != EMPTY);
    end

    // State and data registers; ready held low while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q;

endmodule

// File: rtl/axis_conv_splitter_skid.sv
// Conv input splitter: unpacks one wide AXI-Stream beat into pixel channels,
// weight words and conv tuser, and presents them through a 2-entry skid
// buffer. Counts accepted output beats/packets and flags non-zero pad bits.
// Beat layout, LSB first: pixel ch0..chN-1, weights, tuser, zero pad (MSB).
// Optional macro CONV_SPLITTER_TLAST_CHECK_EN adds expected_beats input and
// a sticky tlast_error output that checks packet length on the input side.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   s_axis_tvalid/tready/tlast   input handshake and packet end
//   s_axis_tdata                 packed input beat
//   m_axis_tvalid/tready/tlast   output handshake and packet end
//   m_axis_pixels_tdata          channel c at [c*UNITS*WORD_WIDTH +: UNITS*WORD_WIDTH]
//   m_axis_weights_tdata         weight words
//   m_axis_tuser                 conv tuser
//   beat_count, packet_count     accepted output beats / tlast beats (wrapping)
//   pad_error                    sticky: a beat arrived with non-zero pad
//   expected_beats, tlast_error  (macro only) packet-length check
module axis_conv_splitter_skid
    import conv_splitter_pkg::*;
#(
    parameter int unsigned PIXEL_CHANNELS = DEF_PIXEL_CHANNELS,
    parameter int unsigned UNITS          = DEF_UNITS,
    parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int unsigned CORES          = DEF_CORES,
    parameter int unsigned KERNEL_W_MAX   = DEF_KERNEL_W_MAX,
    parameter int unsigned TUSER_WIDTH    = DEF_TUSER_WIDTH,
    parameter int unsigned ZEROS_WIDTH    = DEF_ZEROS_WIDTH,
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic                                         s_axis_tvalid,
    output logic                                         s_axis_tready,
    input  logic                                         s_axis_tlast,
    input  logic [PIXEL_CHANNELS*UNITS*WORD_WIDTH
                  + CORES*KERNEL_W_MAX*WORD_WIDTH
                  + TUSER_WIDTH + ZEROS_WIDTH - 1:0]       s_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic [PIXEL_CHANNELS*UNITS*WORD_WIDTH-1:0]   m_axis_pixels_tdata,
    output logic [CORES*KERNEL_W_MAX*WORD_WIDTH-1:0]     m_axis_weights_tdata,
    output logic [TUSER_WIDTH-1:0]                       m_axis_tuser,
    output logic [COUNT_WIDTH-1:0]                       beat_count,
    output logic [COUNT_WIDTH-1:0]                       packet_count,
    output logic                                         pad_error
`ifdef CONV_SPLITTER_TLAST_CHECK_EN
    ,
    input  logic [COUNT_WIDTH-1:0]                       expected_beats,
    output logic                                         tlast_error
`endif
);

    localparam int unsigned PIX_W     = pix_width(PIXEL_CHANNELS, UNITS, WORD_WIDTH);
    localparam int unsigned WGT_W     = wgt_width(CORES, KERNEL_W_MAX, WORD_WIDTH);
    localparam int unsigned WGT_OFS   = wgt_offset(PIX_W);
    localparam int unsigned TUSER_OFS = tuser_offset(PIX_W, WGT_W);
    localparam int unsigned PAD_OFS   = pad_offset(PIX_W, WGT_W, TUSER_WIDTH);
    // Buffered payload: {tlast, tuser, weights, pixels}; pad is dropped
    localparam int unsigned PAY_W     = 1 + PAD_OFS;

    logic [PAY_W-1:0] pay_in_c;
    logic [PAY_W-1:0] pay_out;
    logic             in_c;
    logic             out_c;
    logic             pad_nz_c;

    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [COUNT_WIDTH-1:0] packet_count_q, packet_count_d;
    logic                   pad_error_q, pad_error_d;

    // The low PAD_OFS bits are already {tuser, weights, pixels}
    assign pay_in_c = {s_axis_tlast, s_axis_tdata[PAD_OFS-1:0]};

    axis_skid_buffer #(
        .DATA_WIDTH (PAY_W)
    ) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  (pay_in_c),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (pay_out)
    );

    assign in_c  = s_axis_tvalid & s_axis_tready;
    assign out_c = m_axis_tvalid & m_axis_tready;

    // Unpack the registered payload
    assign m_axis_pixels_tdata  = pay_out[0 +: PIX_W];
    assign m_axis_weights_tdata = pay_out[WGT_OFS +: WGT_W];
    assign m_axis_tuser         = pay_out[TUSER_OFS +: TUSER_WIDTH];
    assign m_axis_tlast         = pay_out[PAY_W-1];

    // Pad field may be absent entirely
    if (ZEROS_WIDTH > 0) begin : g_pad
        assign pad_nz_c = |s_axis_tdata[PAD_OFS +: ZEROS_WIDTH];
    end else begin : g_no_pad
        assign pad_nz_c = 1'b0;
    end

    // Output-side counters and sticky pad flag
    always_comb begin
        beat_count_d   = beat_count_q;
        packet_count_d = packet_count_q;
        pad_error_d    = pad_error_q;
        if (out_c) begin
            beat_count_d = beat_count_q + COUNT_WIDTH'(1);
            if (m_axis_tlast) begin
                packet_count_d = packet_count_q + COUNT_WIDTH'(1);
            end
        end
        if (in_c && pad_nz_c) begin
            pad_error_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_count_q   <= '0;
            packet_count_q <= '0;
            pad_error_q    <= 1'b0;
        end else begin
            beat_count_q   <= beat_count_d;
            packet_count_q <= packet_count_d;
            pad_error_q    <= pad_error_d;
        end
    end

    assign beat_count   = beat_count_q;
    assign packet_count = packet_count_q;
    assign pad_error    = pad_error_q;

`ifdef CONV_SPLITTER_TLAST_CHECK_EN
    logic [COUNT_WIDTH-1:0] beat_idx_q, beat_idx_d;
    logic [COUNT_WIDTH-1:0] exp_q, exp_d;
    logic [COUNT_WIDTH-1:0] exp_cur_c;
    logic                   tlast_error_q, tlast_error_d;

    // Packet length check on accepted input beats; length latched at beat 0
    always_comb begin
        beat_idx_d    = beat_idx_q;
        exp_d         = exp_q;
        tlast_error_d = tlast_error_q;
        exp_cur_c     = (beat_idx_q == '0) ? expected_beats : exp_q;
        if (in_c) begin
            exp_d = exp_cur_c;
            if (s_axis_tlast != (beat_idx_q == exp_cur_c - COUNT_WIDTH'(1))) begin
                tlast_error_d = 1'b1;
            end
            beat_idx_d = s_axis_tlast ? '0 : beat_idx_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_idx_q    <= '0;
            exp_q         <= '0;
            tlast_error_q <= 1'b0;
        end else begin
            beat_idx_q    <= beat_idx_d;
            exp_q         <= exp_d;
            tlast_error_q <= tlast_error_d;
        end
    end

    assign tlast_error = tlast_error_q;
`endif

endmodule

// File: tb/tb_axis_conv_splitter_skid.sv
// Directed bench for axis_conv_splitter_skid (PIXEL_CHANNELS=3).
module tb_axis_conv_splitter_skid;

    localparam int unsigned PC    = 3;
    localparam int unsigned U     = 8;
    localparam int unsigned WW    = 8;
    localparam int unsigned C     = 4;
    localparam int unsigned KW    = 3;
    localparam int unsigned TW    = 16;
    localparam int unsigned ZW    = 5;
    localparam int unsigned CW    = 32;
    localparam int unsigned PIX_W = PC*U*WW;
    localparam int unsigned WGT_W = C*KW*WW;
    localparam int unsigned S_W   = PIX_W + WGT_W + TW + ZW;

    typedef struct packed {
        logic             last;
        logic [TW-1:0]    tu;
        logic [WGT_W-1:0] w;
        logic [PIX_W-1:0] pix;
    } beat_t;

    logic             aclk = 1'b0;
    logic             areset;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [S_W-1:0]   s_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [PIX_W-1:0] m_axis_pixels_tdata;
    logic [WGT_W-1:0] m_axis_weights_tdata;
    logic [TW-1:0]    m_axis_tuser;
    logic [CW-1:0]    beat_count;
    logic [CW-1:0]    packet_count;
    logic             pad_error;
`ifdef CONV_SPLITTER_TLAST_CHECK_EN
    logic [CW-1:0]    expected_beats;
    logic             tlast_error;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    axis_conv_splitter_skid #(
        .PIXEL_CHANNELS (PC),
        .UNITS          (U),
        .WORD_WIDTH     (WW),
        .CORES          (C),
        .KERNEL_W_MAX   (KW),
        .TUSER_WIDTH    (TW),
        .ZEROS_WIDTH    (ZW),
        .COUNT_WIDTH    (CW)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tdata         (s_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_pixels_tdata  (m_axis_pixels_tdata),
        .m_axis_weights_tdata (m_axis_weights_tdata),
        .m_axis_tuser         (m_axis_tuser),
        .beat_count           (beat_count),
        .packet_count         (packet_count),
        .pad_error            (pad_error)
`ifdef CONV_SPLITTER_TLAST_CHECK_EN
        ,
        .expected_beats       (expected_beats),
        .tlast_error          (tlast_error)
`endif
    );

    // Advance one cycle; sample 1ns after the edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Pack a beat in the documented order: {pad, tuser, weights, pixels}
    task automatic drive(input beat_t b, input logic [ZW-1:0] pad);
        s_axis_tdata = {pad, b.tu, b.w, b.pix};
        s_axis_tlast = b.last;
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.last = m_axis_tlast;
        b.tu   = m_axis_tuser;
        b.w    = m_axis_weights_tdata;
        b.pix  = m_axis_pixels_tdata;
        return b;
    endfunction

    // Directed beat: ch0 words = k, ch1 = 0x40+k, ch2 = 0x80+k
    function automatic beat_t seq_beat(input int k, input logic last);
        beat_t b;
        logic [7:0] wb;
        for (int u = 0; u < int'(U); u++) begin
            b.pix[u*8 +: 8]          = 8'(k);
            b.pix[64 + u*8 +: 8]     = 8'(8'h40 + k);
            b.pix[128 + u*8 +: 8]    = 8'(8'h80 + k);
        end
        wb     = 8'(8'hC0 + k);
        b.w    = {12{wb}};
        b.tu   = 16'(16'hBEE0 + k);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < int'(PIX_W/32); i++) b.pix[i*32 +: 32] = $urandom;
        for (int i = 0; i < int'(WGT_W/32); i++) b.w[i*32 +: 32] = $urandom;
        b.tu   = 16'($urandom);
        b.last = ($urandom_range(3) == 0);
        return b;
    endfunction

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
`ifdef CONV_SPLITTER_TLAST_CHECK_EN
        expected_beats = '0;
`endif
        areset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, pad_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/last/pad=%b%b%b%b want 0000",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, pad_error);
        end
        n_tests++;
        if (beat_count !== '0 || packet_count !== '0 || m_axis_pixels_tdata !== '0
            || m_axis_weights_tdata !== '0 || m_axis_tuser !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got beats=%0d pkts=%0d tuser=%h want all 0",
                     beat_count, packet_count, m_axis_tuser);
        end
        areset = 1'b0;
        tick();
        n_tests++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0",
                     s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_basic();
        beat_t e;
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = seq_beat(i + 1, i == 3);
            s_axis_tvalid = 1'b1;
            drive(e, '0);
            tick();
            n_tests++;
            if (m_axis_tvalid !== 1'b1 || cur_out() !== e) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got vld=%b out=%h want vld=1 out=%h",
                         i, m_axis_tvalid, cur_out(), e);
            end
            n_tests++;
            if (m_axis_pixels_tdata[63:0] !== {8{8'(i + 1)}}) begin
                n_fail++;
                $display("FAIL basic_ch0_%0d: got %h want %h", i,
                         m_axis_pixels_tdata[63:0], {8{8'(i + 1)}});
            end
        end
        s_axis_tvalid = 1'b0;
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || beat_count !== 32'd4 || packet_count !== 32'd1
            || pad_error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_counts: got vld=%b beats=%0d pkts=%0d pad=%b want 0 4 1 0",
                     m_axis_tvalid, beat_count, packet_count, pad_error);
        end
    endtask

    task automatic test_stall();
        beat_t a, b, c;
        beat_t got[$];
        logic  acc;
        a = seq_beat(8'h11, 1'b0);
        b = seq_beat(8'h22, 1'b0);
        c = seq_beat(8'h33, 1'b1);
        do_reset();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        drive(a, '0);
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b1 || cur_out() !== a) begin
            n_fail++;
            $display("FAIL stall_first: got vld=%b rdy=%b out=%h want 1 1 %h",
                     m_axis_tvalid, s_axis_tready, cur_out(), a);
        end
        drive(b, '0);
        tick();
        n_tests++;
        if (s_axis_tready !== 1'b0 || cur_out() !== a) begin
            n_fail++;
            $display("FAIL stall_full: got rdy=%b out=%h want rdy=0 out=%h",
                     s_axis_tready, cur_out(), a);
        end
        drive(c, '0);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || cur_out() !== a) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got rdy=%b vld=%b out=%h want 0 1 %h",
                         k, s_axis_tready, m_axis_tvalid, cur_out(), a);
            end
        end
        m_axis_tready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (m_axis_tvalid && m_axis_tready) got.push_back(cur_out());
            acc = s_axis_tvalid && s_axis_tready;
            tick();
            if (acc) s_axis_tvalid = 1'b0;
        end
        n_tests++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats want 3", got.size());
        end else begin
            n_tests++;
            if (got[0] !== a || got[1] !== b || got[2] !== c) begin
                n_fail++;
                $display("FAIL stall_order: got tusers %h %h %h want %h %h %h",
                         got[0].tu, got[1].tu, got[2].tu, a.tu, b.tu, c.tu);
            end
        end
        n_tests++;
        if (beat_count !== 32'd3 || packet_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stall_counts: got beats=%0d pkts=%0d want 3 1",
                     beat_count, packet_count);
        end
    endtask

    task automatic test_random();
        beat_t sb[$];
        beat_t nb, exp_b, prev_out;
        int    issued = 0, sent = 0, lasts = 0, errs = 0;
        logic  in_e, out_e, prev_stall = 1'b0, prev_fire = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && !(sent == 1000 && sb.size() == 0); cyc++) begin
            if (prev_stall && (m_axis_tvalid !== 1'b1 || cur_out() !== prev_out)) errs++;
            if (prev_fire && s_axis_tready !== 1'b1) errs++;
            if (!s_axis_tvalid && issued < 1000 && $urandom_range(1) == 1) begin
                nb = rand_beat();
                drive(nb, '0);
                s_axis_tvalid = 1'b1;
                issued++;
            end
            m_axis_tready = 1'($urandom_range(1));
            in_e  = s_axis_tvalid && s_axis_tready;
            out_e = m_axis_tvalid && m_axis_tready;
            if (out_e) begin
                if (sb.size() == 0) begin
                    errs++;
                end else begin
                    exp_b = sb.pop_front();
                    if (cur_out() !== exp_b) begin
                        errs++;
                        if (errs < 4)
                            $display("FAIL random_beat: got %h want %h", cur_out(), exp_b);
                    end
                end
            end
            if (in_e) begin
                sb.push_back(nb);
                sent++;
                if (nb.last) lasts++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_fire  = out_e;
            prev_out   = cur_out();
            tick();
            if (in_e) s_axis_tvalid = 1'b0;
        end
        m_axis_tready = 1'b1;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL random_scoreboard: got %0d protocol/data errors want 0", errs);
        end
        n_tests++;
        if (sent != 1000 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_done: got sent=%0d pending=%0d want 1000 0",
                     sent, sb.size());
        end
        n_tests++;
        if (beat_count !== CW'(1000) || packet_count !== CW'(lasts)) begin
            n_fail++;
            $display("FAIL random_counts: got beats=%0d pkts=%0d want 1000 %0d",
                     beat_count, packet_count, lasts);
        end
    endtask

    task automatic test_pad();
        do_reset();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        drive(seq_beat(5, 1'b0), '0);
        tick();
        n_tests++;
        if (pad_error !== 1'b0) begin
            n_fail++;
            $display("FAIL pad_clean: got %b want 0", pad_error);
        end
        drive(seq_beat(6, 1'b0), 5'b00100);
        tick();
        n_tests++;
        if (pad_error !== 1'b1) begin
            n_fail++;
            $display("FAIL pad_set: got %b want 1", pad_error);
        end
        for (int i = 0; i < 10; i++) begin
            drive(seq_beat(7 + i, i == 9), '0);
            tick();
            n_tests++;
            if (pad_error !== 1'b1) begin
                n_fail++;
                $display("FAIL pad_sticky%0d: got %b want 1", i, pad_error);
            end
        end
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        n_tests++;
        if (pad_error !== 1'b0) begin
            n_fail++;
            $display("FAIL pad_clear: got %b want 0", pad_error);
        end
        areset = 1'b0;
        tick();
        // Top pad bit alone must also be caught
        s_axis_tvalid = 1'b1;
        drive(seq_beat(9, 1'b1), 5'b10000);
        tick();
        s_axis_tvalid = 1'b0;
        n_tests++;
        if (pad_error !== 1'b1) begin
            n_fail++;
            $display("FAIL pad_msb: got %b want 1", pad_error);
        end
        tick();
    endtask

    task automatic test_reset_full();
        do_reset();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        drive(seq_beat(1, 1'b1), '0);
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        n_tests++;
        if (beat_count !== 32'd1 || packet_count !== 32'd1) begin
            n_fail++;
            $display("FAIL rstfull_pre: got beats=%0d pkts=%0d want 1 1",
                     beat_count, packet_count);
        end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        drive(seq_beat(2, 1'b0), '0);
        tick();
        drive(seq_beat(3, 1'b1), '0);
        tick();
        s_axis_tvalid = 1'b0;
        n_tests++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstfull_full: got rdy=%b vld=%b want 0 1",
                     s_axis_tready, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        areset = 1'b1;
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || beat_count !== '0
            || packet_count !== '0) begin
            n_fail++;
            $display("FAIL rstfull_reset: got vld=%b rdy=%b beats=%0d pkts=%0d want 0 0 0 0",
                     m_axis_tvalid, s_axis_tready, beat_count, packet_count);
        end
        areset = 1'b0;
        tick();
        n_tests++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfull_release: got rdy=%b vld=%b want 1 0",
                     s_axis_tready, m_axis_tvalid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m_axis_tvalid !== 1'b0 || beat_count !== '0) begin
                n_fail++;
                $display("FAIL rstfull_noemit%0d: got vld=%b beats=%0d want 0 0",
                         i, m_axis_tvalid, beat_count);
            end
        end
    endtask

`ifdef CONV_SPLITTER_TLAST_CHECK_EN
    // Send n beats with tlast on beat index last_idx (or never if out of range)
    task automatic send_pkt(input int n, input int last_idx, input string tag);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(seq_beat(i, i == last_idx), '0);
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick();
    endtask

    task automatic test_tlast_check();
        do_reset();
        m_axis_tready  = 1'b1;
        expected_beats = 32'd3;
        send_pkt(2, 1, "early");
        n_tests++;
        if (tlast_error !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_early: got %b want 1", tlast_error);
        end
        do_reset();
        send_pkt(3, 2, "exact");
        send_pkt(3, 2, "exact2");
        n_tests++;
        if (tlast_error !== 1'b0) begin
            n_fail++;
            $display("FAIL tlast_exact: got %b want 0", tlast_error);
        end
        send_pkt(3, 99, "missing");
        n_tests++;
        if (tlast_error !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_missing: got %b want 1", tlast_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_pad();
        test_reset_full();
`ifdef CONV_SPLITTER_TLAST_CHECK_EN
        test_tlast_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
